// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_if
// Brief   : CPU-side holding/receive registers plus SPI pins of spi_slave.
// Revision: 1.0  initial release
// ============================================================================
interface spi_slave_if;
   logic        wide;
   logic [31:0] txData;
   logic        txLoad;
   logic        txEmpty;
   logic [31:0] rxData;
   logic        rxValid;
   logic        rxAck;
   logic        overrun;
   logic        busy;
   logic        SCLK;
   logic        MOSI;
   logic        SSn;
   logic        MISO;

   modport slave (
      input  wide, txData, txLoad, rxAck, SCLK, MOSI, SSn,
      output txEmpty, rxData, rxValid, overrun, busy, MISO
   );

   modport master (
      output wide, txData, txLoad, rxAck, SCLK, MOSI, SSn,
      input  txEmpty, rxData, rxValid, overrun, busy, MISO
   );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave
// Brief   : Mode-0 SPI target, byte or 32-bit word (LSByte first, MSbit first),
//           pins oversampled in clk. Optional macro: SPI_SLAVE_OVERRUN_EN.
// Revision: 1.0  initial release
// ============================================================================
module spi_slave (
   input  wire logic   clk,
   input  wire logic   rst,
   spi_slave_if.slave  bus
);
   typedef enum logic [1:0] {
      WAITIDLE = 2'd0,
      IDLE     = 2'd1,
      SHIFT    = 2'd2
   } state_t;

   state_t      r_state;
   // [0],[1] synchroniser, [2] history
   logic [2:0]  r_sclk_sync;
   logic [2:0]  r_mosi_sync;
   logic [2:0]  r_ssn_sync;
   logic        r_rise;
   logic        r_fall;
   logic        r_ss_fall;

   logic [4:0]  r_bit_k;
   logic        r_wide;
   logic [31:0] r_hold;
   logic [31:0] r_tx_sh;
   logic [31:0] r_rx_sh;
   logic        r_tx_empty;
   logic [31:0] r_rx_data;
   logic        r_rx_valid;
   logic        r_overrun;
   logic        r_miso;

   logic [4:0]  w_last;
   logic [4:0]  w_idx;
   logic [4:0]  w_next_k;
   logic [4:0]  w_next_idx;
   logic [31:0] w_start_tx;
   logic [31:0] w_rx_next;
   logic        w_word_start;
   logic        w_complete;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= 3'b000;
         r_mosi_sync <= 3'b000;
         // SSn chain resets to "selected" so WAITIDLE only leaves on a real high
         r_ssn_sync  <= 3'b000;
         r_rise      <= 1'b0;
         r_fall      <= 1'b0;
         r_ss_fall   <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], bus.SCLK};
         r_mosi_sync <= {r_mosi_sync[1:0], bus.MOSI};
         r_ssn_sync  <= {r_ssn_sync[1:0], bus.SSn};
         r_rise      <= r_sclk_sync[1] & ~r_sclk_sync[2];
         r_fall      <= ~r_sclk_sync[1] & r_sclk_sync[2];
         r_ss_fall   <= ~r_ssn_sync[1] & r_ssn_sync[2];
      end
   end

   // Serial bit k lands on word bit {k[4:3], ~k[2:0]}
   assign w_last     = r_wide ? 5'd31 : 5'd7;
   assign w_idx      = {r_bit_k[4:3], ~r_bit_k[2:0]};
   assign w_next_k   = r_bit_k + 5'd1;
   assign w_next_idx = {w_next_k[4:3], ~w_next_k[2:0]};
   assign w_start_tx = r_tx_empty ? 32'hFFFF_FFFF : r_hold;

   always_comb begin
      w_rx_next        = r_rx_sh;
      w_rx_next[w_idx] = r_mosi_sync[2];
   end

   always_comb begin
      w_word_start = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         IDLE:  w_word_start = r_ss_fall;
         SHIFT: begin
            if (!r_ssn_sync[1]) begin
               w_word_start = r_fall && (r_bit_k == w_last);
               w_complete   = r_rise && (r_bit_k == w_last);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= WAITIDLE;
         r_bit_k    <= 5'd0;
         r_wide     <= 1'b0;
         r_hold     <= 32'd0;
         r_tx_sh    <= 32'hFFFF_FFFF;
         r_rx_sh    <= 32'd0;
         r_tx_empty <= 1'b1;
         r_rx_data  <= 32'd0;
         r_rx_valid <= 1'b0;
         r_overrun  <= 1'b0;
         r_miso     <= 1'b1;
      end else begin
         case (r_state)
            WAITIDLE: begin
               r_miso <= 1'b1;
               if (r_ssn_sync[1]) r_state <= IDLE;
            end
            IDLE: begin
               r_miso <= 1'b1;
               if (r_ss_fall) r_state <= SHIFT;
            end
            SHIFT: begin
               if (r_ssn_sync[1]) begin
                  r_state <= IDLE;
                  r_miso  <= 1'b1;
               end else begin
                  if (r_rise) r_rx_sh <= w_rx_next;
                  if (r_fall && (r_bit_k != w_last)) begin
                     r_bit_k <= w_next_k;
                     r_miso  <= r_tx_sh[w_next_idx];
                  end
               end
            end
            default: r_state <= WAITIDLE;
         endcase

         if (w_word_start) begin
            r_bit_k    <= 5'd0;
            r_wide     <= bus.wide;
            r_tx_sh    <= w_start_tx;
            r_miso     <= w_start_tx[7];
            r_rx_sh    <= 32'd0;
            r_tx_empty <= 1'b1;
         end

         // A load in the same cycle as a word start refills the holding register
         if (bus.txLoad) begin
            r_hold     <= bus.txData;
            r_tx_empty <= 1'b0;
         end

         if (w_complete)
            r_rx_data <= r_wide ? w_rx_next : {24'd0, w_rx_next[7:0]};

         if (bus.rxAck)  r_rx_valid <= 1'b0;
         if (w_complete) r_rx_valid <= 1'b1;

`ifdef SPI_SLAVE_OVERRUN_EN
         if (bus.rxAck && r_overrun) r_overrun <= 1'b0;
         if (w_complete && r_rx_valid && !bus.rxAck) r_overrun <= 1'b1;
`else
         r_overrun <= 1'b0;
`endif
      end
   end

   assign bus.txEmpty = r_tx_empty;
   assign bus.rxData  = r_rx_data;
   assign bus.rxValid = r_rx_valid;
   assign bus.overrun = r_overrun;
   assign bus.busy    = (r_state == SHIFT);
   assign bus.MISO    = r_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave
// Brief   : Self-checking bench for spi_slave: vector table, corner sequences,
//           random frames against a word-level reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_spi_slave;
`ifdef SPI_SLAVE_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   spi_slave_if bus ();
   spi_slave dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Reference model: holding register and receive flags
   bit          m_hold_full = 1'b0;
   logic [31:0] m_hold_val  = 32'd0;
   bit          m_rxvalid   = 1'b0;
   bit          m_ovr       = 1'b0;

   logic [31:0] f_mosi[4];
   logic [31:0] f_miso[4];

   typedef struct {
      bit          wd;
      bit          load;
      logic [31:0] tx;
      logic [31:0] rx;
      logic [31:0] exp_miso;
      logic [31:0] exp_rx;
   } vec_t;
   vec_t tbl[5];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mask(input logic [31:0] v, input bit wd);
      return wd ? v : {24'd0, v[7:0]};
   endfunction

   function automatic logic [31:0] model_start();
      if (m_hold_full) begin
         m_hold_full = 1'b0;
         return m_hold_val;
      end
      return 32'hFFFF_FFFF;
   endfunction

   function automatic void model_complete(input bit ack);
      m_ovr     = (m_ovr && !ack) || (OVR_EN && m_rxvalid && !ack);
      m_rxvalid = 1'b1;
   endfunction

   task automatic do_load(input logic [31:0] v);
      bus.txData = v;
      bus.txLoad = 1'b1;
      tick(1);
      bus.txLoad = 1'b0;
      m_hold_full = 1'b1;
      m_hold_val  = v;
   endtask

   task automatic ack_pulse();
      bus.rxAck = 1'b1;
      tick(1);
      bus.rxAck = 1'b0;
      m_rxvalid = 1'b0;
      m_ovr     = 1'b0;
   endtask

   // Master side: 6-clk SCLK phases, MISO sampled just before each rising edge
   task automatic send_bits(input logic [31:0] mw, input int nbits, input bit ack_last,
                            output logic [31:0] got);
      got = 32'd0;
      for (int k = 0; k < nbits; k++) begin
         int pos;
         pos = 8 * (k / 8) + 7 - (k % 8);
         bus.MOSI = mw[pos];
         tick(6);
         got[pos] = bus.MISO;
         bus.SCLK = 1'b1;
         if (ack_last && k == nbits - 1) begin
            tick(3);
            bus.rxAck = 1'b1;
            tick(1);
            bus.rxAck = 1'b0;
            tick(2);
         end else begin
            tick(6);
         end
         bus.SCLK = 1'b0;
      end
   endtask

   // ack_mode: 0 none, 1 pulse after each word, 2 on the completion cycle
   task automatic frame(input bit wd, input int nw, input int ack_mode);
      logic [31:0] exp_tx[4];
      logic [31:0] got;
      bit          ack_now;
      bus.wide = wd;
      for (int j = 0; j < nw; j++) exp_tx[j] = model_start();
      void'(model_start());
      bus.SSn = 1'b0;
      tick(6);
      chk("txempty_after_start", {31'd0, bus.txEmpty}, 32'd1);
      chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
      for (int j = 0; j < nw; j++) begin
         ack_now = (ack_mode == 2);
         send_bits(f_mosi[j], wd ? 32 : 8, ack_now, got);
         f_miso[j] = got;
         model_complete(ack_now);
         chk("miso_word", got, mask(exp_tx[j], wd));
         chk("rxvalid_set", {31'd0, bus.rxValid}, 32'd1);
         chk("rxdata", bus.rxData, mask(f_mosi[j], wd));
         chk("overrun", {31'd0, bus.overrun}, {31'd0, m_ovr});
         if (ack_mode == 1) begin
            ack_pulse();
            chk("rxvalid_cleared", {31'd0, bus.rxValid}, 32'd0);
         end
      end
      tick(6);
      bus.SSn = 1'b1;
      tick(6);
      chk("busy_after_frame", {31'd0, bus.busy}, 32'd0);
      chk("miso_idle", {31'd0, bus.MISO}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_txempty"}, {31'd0, bus.txEmpty}, 32'd1);
      chk({tag, "_rxdata"},  bus.rxData, 32'd0);
      chk({tag, "_rxvalid"}, {31'd0, bus.rxValid}, 32'd0);
      chk({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
      chk({tag, "_busy"},    {31'd0, bus.busy}, 32'd0);
      chk({tag, "_miso"},    {31'd0, bus.MISO}, 32'd1);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a_val;
      logic [31:0] b_val;
      bus.wide = 1'b0; bus.txData = 32'd0; bus.txLoad = 1'b0; bus.rxAck = 1'b0;
      bus.SCLK = 1'b0; bus.MOSI = 1'b0; bus.SSn = 1'b1;

      tbl[0] = '{wd: 1'b0, load: 1'b1, tx: 32'h0000_00A5, rx: 32'h0000_003C, exp_miso: 32'h0000_00A5, exp_rx: 32'h0000_003C};
      tbl[1] = '{wd: 1'b1, load: 1'b1, tx: 32'h1234_5678, rx: 32'hDEAD_BEEF, exp_miso: 32'h1234_5678, exp_rx: 32'hDEAD_BEEF};
      tbl[2] = '{wd: 1'b0, load: 1'b0, tx: 32'h0000_0000, rx: 32'h0000_0081, exp_miso: 32'h0000_00FF, exp_rx: 32'h0000_0081};
      tbl[3] = '{wd: 1'b1, load: 1'b0, tx: 32'h0000_0000, rx: 32'h0000_0001, exp_miso: 32'hFFFF_FFFF, exp_rx: 32'h0000_0001};
      tbl[4] = '{wd: 1'b0, load: 1'b1, tx: 32'hFFFF_FF5A, rx: 32'h0000_00FF, exp_miso: 32'h0000_005A, exp_rx: 32'h0000_00FF};

      tick(3);
      rst = 1'b0;
      tick(3);
      chk_reset_outputs("reset");

      for (int i = 0; i < 5; i++) begin
         if (tbl[i].load) begin
            do_load(tbl[i].tx);
            chk("tbl_txempty_loaded", {31'd0, bus.txEmpty}, 32'd0);
         end
         f_mosi[0] = tbl[i].rx;
         frame(tbl[i].wd, 1, 1);
         chk("tbl_miso", f_miso[0], tbl[i].exp_miso);
         chk("tbl_rxdata", bus.rxData, tbl[i].exp_rx);
      end

      // Two bytes in one select, nothing loaded
      f_mosi[0] = 32'h5C;
      f_mosi[1] = 32'hE7;
      frame(1'b0, 2, 1);
      chk("b2b_rxdata_second", bus.rxData, 32'h0000_00E7);

      // txLoad on the word-start cycle: old contents go out, new ones stay held
      a_val = 32'h0000_00C6;
      b_val = 32'h0000_0039;
      do_load(a_val);
      bus.wide = 1'b0;
      bus.SSn  = 1'b0;
      tick(3);
      bus.txData = b_val;
      bus.txLoad = 1'b1;
      tick(1);
      bus.txLoad = 1'b0;
      tick(2);
      chk("simul_txempty", {31'd0, bus.txEmpty}, 32'd0);
      send_bits(32'h0000_0017, 8, 1'b0, got);
      model_complete(1'b0);
      chk("simul_miso", got, a_val);
      chk("simul_rxdata", bus.rxData, 32'h0000_0017);
      tick(6);
      chk("simul_txempty_end", {31'd0, bus.txEmpty}, 32'd1);
      bus.SSn = 1'b1;
      tick(6);
      m_hold_full = 1'b0;
      ack_pulse();

      // Abort after 5 bits, then a clean byte
      bus.wide = 1'b0;
      void'(model_start());
      bus.SSn = 1'b0;
      tick(6);
      send_bits(32'h0000_00FF, 5, 1'b0, got);
      tick(2);
      bus.SSn = 1'b1;
      tick(6);
      chk("abort_rxvalid", {31'd0, bus.rxValid}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_miso", {31'd0, bus.MISO}, 32'd1);
      f_mosi[0] = 32'hC3;
      frame(1'b0, 1, 1);

      // Overrun: two bytes without ack, then with ack on completion
      f_mosi[0] = 32'h11;
      f_mosi[1] = 32'h22;
      frame(1'b0, 2, 0);
      chk("ovr_rxdata", bus.rxData, 32'h0000_0022);
      chk("ovr_flag", {31'd0, bus.overrun}, {31'd0, OVR_EN});
      ack_pulse();
      chk("ovr_cleared", {31'd0, bus.overrun}, 32'd0);
      f_mosi[0] = 32'h33;
      f_mosi[1] = 32'h44;
      frame(1'b0, 2, 2);
      chk("ovr_ack_flag", {31'd0, bus.overrun}, 32'd0);
      chk("ovr_ack_rxvalid", {31'd0, bus.rxValid}, 32'd1);
      ack_pulse();

      // Random frames against the model
      for (int r = 0; r < 12; r++) begin
         bit wd;
         int nw;
         wd = 1'($urandom_range(0, 1));
         nw = $urandom_range(1, 2);
         if ($urandom_range(0, 1) == 1) do_load($urandom);
         for (int j = 0; j < nw; j++) f_mosi[j] = $urandom;
         frame(wd, nw, $urandom_range(0, 2));
      end
      ack_pulse();

      // Reset during bit 3 with SSn held low
      bus.wide = 1'b0;
      void'(model_start());
      bus.SSn = 1'b0;
      tick(6);
      do_load(32'h0000_000F);
      send_bits(32'h0000_00AA, 3, 1'b0, got);
      bus.MOSI = 1'b1;
      tick(6);
      bus.SCLK = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      m_hold_full = 1'b0;
      m_rxvalid   = 1'b0;
      m_ovr       = 1'b0;
      chk_reset_outputs("rstmid_edge");
      tick(4);
      chk_reset_outputs("rstmid");
      tick(2);
      bus.SCLK = 1'b0;
      send_bits(32'h0000_00FF, 8, 1'b0, got);
      tick(6);
      chk("rstmid_no_rx", {31'd0, bus.rxValid}, 32'd0);
      chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rstmid_miso", {31'd0, bus.MISO}, 32'd1);
      bus.SSn = 1'b1;
      tick(6);
      f_mosi[0] = 32'h96;
      frame(1'b0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
